lfsr_equiv_checker: RTL and testbench

Self-contained, synthesisable normal-operation equivalence checker for scan/JTAG-inserted netlists. Generates pseudo-random primary-input vectors with a parametrised LFSR and drives them to a modified design and its golden original in parallel. Compares both output buses after a configurable pipeline latency, counts vectors and captures the first mismatch. Sits alongside any DUT/golden pair and runs on the functional clock.

---
 rtl/lfsr_equiv_checker.sv | 84 ++++++++
 tb/tb_lfsr_equiv_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_equiv_checker.sv
// lfsr_equiv_checker: LFSR-driven DUT/golden output comparator; define EQC_MISR_EN to get a po_dut MISR on sig
module lfsr_equiv_checker #(
  parameter int PI_W = 36,
  parameter int PO_W = 39,
  parameter int CNT_W = 19,
  parameter int NUM_VEC = 131071,
  parameter int LAT = 1,
  parameter logic [PI_W-1:0] SEED = 1,
  parameter logic [PI_W-1:0] TAPS = 36'h801000000
) (
  input  logic CK,
  input  logic RST,
  input  logic start,
  input  logic [PO_W-1:0] po_dut,
  input  logic [PO_W-1:0] po_gold,
  output logic [PI_W-1:0] pi,
  output logic busy,
  output logic done,
  output logic pass,
  output logic fail,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] fail_index,
  output logic [PO_W-1:0] fail_diff,
  output logic [PO_W-1:0] sig
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VEC);
  localparam logic [PI_W-1:0] SEED_EFF = (SEED == '0) ? PI_W'(1) : SEED;
  state_t state, state_n;
  logic [PI_W-1:0] lfsr, src, step;
  logic [CNT_W-1:0] idx;
  logic [LAT-1:0] vld;
  logic [CNT_W-1:0] tok [LAT];
  logic go, issue, push, cmp, miss;
  always_comb begin
    go = start && state != RUN;
    issue = state == RUN && idx < NV;
    push = go || issue;
    cmp = state == RUN && vld[LAT-1];
    miss = cmp && po_dut != po_gold;
    src = go ? SEED_EFF : lfsr;
    step = (src >> 1) ^ (src[0] ? TAPS : '0);
    state_n = go ? RUN : miss ? FAIL : (state == RUN && !issue && vld == '0) ? PASS : state;
  end
  assign busy = state == RUN;
  assign done = state == PASS || state == FAIL;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  always_ff @(posedge CK) state <= RST ? IDLE : state_n;
  // start issues vector 0 straight from SEED so it appears on pi right after the start edge
  always_ff @(posedge CK) begin
    if (RST) begin
      lfsr <= '0;
      pi <= '0;
      idx <= '0;
      vld <= '0;
      vec_count <= '0;
      fail_index <= '0;
      fail_diff <= '0;
    end else begin
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1] && !go;
        tok[i] <= tok[i-1];
      end
      vld[0] <= push;
      tok[0] <= go ? '0 : idx;
      if (push) begin
        pi <= src;
        lfsr <= step;
        idx <= (go ? '0 : idx) + CNT_W'(1);
      end
      vec_count <= go ? '0 : (cmp && !miss) ? vec_count + CNT_W'(1) : vec_count;
      if (go || miss) begin
        fail_index <= go ? '0 : tok[LAT-1];
        fail_diff <= go ? '0 : po_dut ^ po_gold;
      end
    end
  end
`ifdef EQC_MISR_EN
  always_ff @(posedge CK) sig <= (RST || go) ? '0 : cmp ? {sig[PO_W-2:0], sig[PO_W-1]} ^ po_dut : sig;
`else
  assign sig = '0;
`endif
endmodule

// File: tb/tb_lfsr_equiv_checker.sv
// tb_lfsr_equiv_checker: randomized self-checking bench over three parameterisations
module tb_lfsr_equiv_checker;
  logic CK = 0;
  logic RST = 1;
  always #5 CK = ~CK;
  logic start_a [3];
  logic [38:0] dut_a [3];
  logic [38:0] gold_a [3];
  logic [38:0] diff_a [3];
  logic [38:0] sig_a [3];
  logic [38:0] mask_a [3];
  logic [35:0] pi_a [3];
  logic [35:0] pd_a [3];
  logic [35:0] d1 [3];
  logic [35:0] d2 [3];
  logic [35:0] bad_vec [3];
  logic busy_a [3];
  logic done_a [3];
  logic pass_a [3];
  logic fail_a [3];
  logic bad_en [3];
  logic [18:0] vc_a [3];
  logic [18:0] fi_a [3];
  logic [35:0] vecs [16];
  int lat_of [3];
  int nv_of [3];
  int checks = 0;
  int errors = 0;

  lfsr_equiv_checker #(.NUM_VEC(16), .LAT(1)) u0 (.CK(CK), .RST(RST), .start(start_a[0]), .po_dut(dut_a[0]),
    .po_gold(gold_a[0]), .pi(pi_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .fail(fail_a[0]),
    .vec_count(vc_a[0]), .fail_index(fi_a[0]), .fail_diff(diff_a[0]), .sig(sig_a[0]));
  lfsr_equiv_checker #(.NUM_VEC(16), .LAT(3)) u1 (.CK(CK), .RST(RST), .start(start_a[1]), .po_dut(dut_a[1]),
    .po_gold(gold_a[1]), .pi(pi_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .fail(fail_a[1]),
    .vec_count(vc_a[1]), .fail_index(fi_a[1]), .fail_diff(diff_a[1]), .sig(sig_a[1]));
  lfsr_equiv_checker #(.NUM_VEC(1), .LAT(3)) u2 (.CK(CK), .RST(RST), .start(start_a[2]), .po_dut(dut_a[2]),
    .po_gold(gold_a[2]), .pi(pi_a[2]), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .fail(fail_a[2]),
    .vec_count(vc_a[2]), .fail_index(fi_a[2]), .fail_diff(diff_a[2]), .sig(sig_a[2]));

  function automatic logic [38:0] gfun(input logic [35:0] x);
    return {x[2:0], x} ^ 39'h2A5A5A0F0F;
  endfunction

  // golden designs: combinational for LAT=1, two-register pipelines for LAT=3
  always @(posedge CK) for (int j = 0; j < 3; j++) begin
    d1[j] <= pi_a[j];
    d2[j] <= d1[j];
  end
  always_comb for (int j = 0; j < 3; j++) begin
    pd_a[j] = (j == 0) ? pi_a[j] : d2[j];
    gold_a[j] = gfun(pd_a[j]);
    dut_a[j] = gold_a[j] ^ ((bad_en[j] && pd_a[j] == bad_vec[j]) ? mask_a[j] : 39'h0);
  end

  task automatic run(input int j, input int bad, input logic [38:0] m, input bit mid_start);
    int n, l, dc, vc, pk, last;
    logic [38:0] s;
    n = nv_of[j];
    l = lat_of[j];
    bad_en[j] = bad >= 0;
    bad_vec[j] = bad >= 0 ? vecs[bad] : 36'h0;
    mask_a[j] = m;
    dc = bad >= 0 ? bad + l : n + l;
    @(negedge CK);
    start_a[j] = 1;
    for (int c = 0; c <= dc + 2; c++) begin
      @(negedge CK);
      start_a[j] = mid_start && c == 3;
      pk = c < n - 1 ? c : n - 1;
      if (pk > dc) pk = dc;
      vc = c - l + 1;
      if (vc < 0) vc = 0;
      if (vc > n) vc = n;
      if (bad >= 0 && vc > bad) vc = bad;
      checks++;
      if (pi_a[j] !== vecs[pk]) begin errors++; $display("FAIL pi j=%0d c=%0d got %h exp %h", j, c, pi_a[j], vecs[pk]); end
      checks++;
      if (busy_a[j] !== (c < dc)) begin errors++; $display("FAIL busy j=%0d c=%0d got %b exp %b", j, c, busy_a[j], c < dc); end
      checks++;
      if (done_a[j] !== (c >= dc)) begin errors++; $display("FAIL done j=%0d c=%0d got %b exp %b", j, c, done_a[j], c >= dc); end
      checks++;
      if (vc_a[j] !== 19'(vc)) begin errors++; $display("FAIL vec_count j=%0d c=%0d got %0d exp %0d", j, c, vc_a[j], vc); end
      if (c == 0) begin
        checks++;
        if (fi_a[j] !== 19'h0 || diff_a[j] !== 39'h0) begin
          errors++; $display("FAIL clear j=%0d got idx %0d diff %h exp 0 0", j, fi_a[j], diff_a[j]);
        end
      end
    end
    s = '0;
    last = bad >= 0 ? bad : n - 1;
    for (int k = 0; k <= last; k++) s = {s[37:0], s[38]} ^ gfun(vecs[k]) ^ (k == bad ? m : 39'h0);
`ifndef EQC_MISR_EN
    s = '0;
`endif
    checks++;
    if (pass_a[j] !== (bad < 0) || fail_a[j] !== (bad >= 0)) begin
      errors++; $display("FAIL verdict j=%0d got pass %b fail %b exp pass %b", j, pass_a[j], fail_a[j], bad < 0);
    end
    checks++;
    if (fi_a[j] !== 19'(bad >= 0 ? bad : 0)) begin errors++; $display("FAIL fail_index j=%0d got %0d exp %0d", j, fi_a[j], bad); end
    checks++;
    if (diff_a[j] !== (bad >= 0 ? m : 39'h0)) begin errors++; $display("FAIL fail_diff j=%0d got %h exp %h", j, diff_a[j], m); end
    checks++;
    if (sig_a[j] !== s) begin errors++; $display("FAIL sig j=%0d got %h exp %h", j, sig_a[j], s); end
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (pi_a[j] !== '0 || busy_a[j] !== 0 || done_a[j] !== 0 || pass_a[j] !== 0 || fail_a[j] !== 0 ||
          vc_a[j] !== '0 || fi_a[j] !== '0 || diff_a[j] !== '0 || sig_a[j] !== '0) begin
        errors++;
        $display("FAIL %s j=%0d got pi %h busy %b done %b pass %b fail %b cnt %0d exp all zero",
                 tag, j, pi_a[j], busy_a[j], done_a[j], pass_a[j], fail_a[j], vc_a[j]);
      end
    end
  endtask

  function automatic logic [38:0] rmask();
    logic [38:0] m;
    m = 39'({$urandom, $urandom});
    return m == 0 ? 39'h1 : m;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge CK);
    @(negedge CK);
    RST = 0;
    check_zero("reset");
    start_a[0] = 1;
    @(negedge CK);
    start_a[0] = 0;
    repeat (4) @(negedge CK);
    RST = 1;
    repeat (2) @(negedge CK);
    RST = 0;
    check_zero("reset_mid_run");
    @(negedge CK);
    check_zero("idle_after_reset");
  endtask

  task automatic test_clean();
    run(0, -1, 39'h0, 0);
  endtask

  task automatic test_inject();
    run(0, 5, 39'h80, 0);
    run(0, int'($urandom_range(0, 15)), rmask(), 0);
  endtask

  task automatic test_lat3();
    run(1, 0, rmask(), 0);
    run(1, int'($urandom_range(0, 15)), rmask(), 0);
    run(1, -1, 39'h0, 0);
    run(2, -1, 39'h0, 0);
    run(2, 0, rmask(), 0);
  endtask

  task automatic test_start_ignored();
    run(0, -1, 39'h0, 1);
  endtask

  task automatic test_back_to_back();
    run(0, 9, rmask(), 0);
    run(0, -1, 39'h0, 0);
    run(0, int'($urandom_range(0, 15)), rmask(), 0);
  endtask

  initial begin
    logic [35:0] v;
    lat_of = '{1, 3, 3};
    nv_of = '{16, 16, 1};
    for (int j = 0; j < 3; j++) begin
      start_a[j] = 0;
      bad_en[j] = 0;
      bad_vec[j] = '0;
      mask_a[j] = '0;
    end
    v = 36'h1;
    for (int k = 0; k < 16; k++) begin
      vecs[k] = v;
      v = v[0] ? (v >> 1) ^ 36'h801000000 : v >> 1;
    end
    test_reset();
    test_clean();
    test_inject();
    test_lat3();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
